vx_ctrl_apb_multi: RTL and testbench

APB-programmed control and address-remap block for third-party accelerator cores (Vortex first). It is the parametrised successor to the single-base Vortex wrapper control logic.
- Sequences the core through a timed reset and run, detects completion and raises a maskable interrupt.
- Counts run cycles.
- Translates core AXI addresses through NUM_REGIONS programmable base registers instead of one global offset.
- Sits between the ESP APB socket and the core's clock-enable, reset and AXI AR/AW address paths.

---
 rtl/vx_ctrl_apb_multi.sv | 174 +++++++++++++++++
 tb/tb_vx_ctrl_apb_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_ctrl_apb_multi.sv
// APB control and multi-region AXI address remap for accelerator cores (Vortex first).
// Optional run-cycle counter enabled by defining VX_CTRL_CYCLE_CNT_EN.
//
// state   | meaning
// IDLE    | core clock gated, core held in reset
// RESET   | core clocked, reset held for RESET_DELAY cycles
// RUN     | core running, waiting for busy to rise then fall
// DONE    | one-cycle completion, sets irq pending
module vx_ctrl_apb_multi #(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int RESET_DELAY = 8,
  parameter int CTR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic                  core_busy,
  output logic                  core_clk_en,
  output logic                  core_reset,
  input  logic [ADDR_WIDTH-1:0] araddr_raw,
  input  logic [ADDR_WIDTH-1:0] awaddr_raw,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  irq
);

  localparam int RSEL = $clog2(NUM_REGIONS);
  localparam int RCW  = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = {ADDR_WIDTH{1'b1}} >> RSEL;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESET = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

  state_t                state;
  logic [RCW-1:0]        rst_ctr;
  logic                  seen_busy;
  logic                  pending;
  logic                  enable;
  logic [ADDR_WIDTH-1:0] base_q [NUM_REGIONS];
  logic [31:0]           cycles_rd;

  logic [7:0]      off;
  logic [7:0]      base_off;
  logic [RSEL-1:0] base_sel;
  logic            is_ctrl, is_status, is_irq, is_cycles, is_base, mapped;
  logic            access, wr, wr_ctrl, wr_irq, wr_base, start_req, abort_req;

  assign off       = paddr[7:0];
  assign base_off  = off - 8'h10;
  assign base_sel  = base_off[RSEL+1:2];
  assign is_ctrl   = (off == 8'h00);
  assign is_status = (off == 8'h04);
  assign is_irq    = (off == 8'h08);
  assign is_cycles = (off == 8'h0C);
  assign is_base   = (off[1:0] == 2'b00) && (off >= 8'h10) && (int'(off) < 16 + 4 * NUM_REGIONS);
  assign mapped    = is_ctrl | is_status | is_irq | is_cycles | is_base;

  assign access  = psel & penable;
  assign pslverr = access & (~mapped | (pwrite & (is_status | is_cycles))
                             | (pwrite & is_base & (state != S_IDLE)));
  assign pready  = 1'b1;

  // Erroring accesses never reach any register
  assign wr        = access & pwrite & ~pslverr;
  assign wr_ctrl   = wr & is_ctrl;
  assign wr_irq    = wr & is_irq;
  assign wr_base   = wr & is_base;
  assign abort_req = wr_ctrl & pwdata[1];
  assign start_req = wr_ctrl & pwdata[0] & ~pwdata[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      core_clk_en <= 1'b0;
      core_reset  <= 1'b1;
      rst_ctr     <= '0;
      seen_busy   <= 1'b0;
    end else if (abort_req) begin
      state       <= S_IDLE;
      core_clk_en <= 1'b0;
      core_reset  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start_req) begin
          state       <= S_RESET;
          core_clk_en <= 1'b1;
          core_reset  <= 1'b1;
          rst_ctr     <= '0;
          seen_busy   <= 1'b0;
        end
        S_RESET: begin
          rst_ctr <= rst_ctr + 1'b1;
          if (rst_ctr == RCW'(RESET_DELAY - 1)) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
          end
        end
        S_RUN: begin
          if (core_busy) seen_busy <= 1'b1;
          else if (seen_busy) begin
            state       <= S_DONE;
            core_clk_en <= 1'b0;
          end
        end
        default: begin
          state      <= S_IDLE;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

  // Completion set has priority over a same-cycle W1C
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      enable  <= 1'b0;
    end else begin
      if (state == S_DONE && !abort_req) pending <= 1'b1;
      else if (wr_irq && pwdata[0])      pending <= 1'b0;
      if (wr_irq) enable <= pwdata[1];
    end
  end

  assign irq = pending & enable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGIONS; i++) base_q[i] <= '0;
    end else if (wr_base) begin
      base_q[base_sel] <= pwdata[ADDR_WIDTH-1:0];
    end
  end

`ifdef VX_CTRL_CYCLE_CNT_EN
  logic [CTR_WIDTH-1:0] cycles_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  cycles_q <= '0;
    else if (state == S_IDLE && start_req)       cycles_q <= '0;
    else if (state == S_RUN && !(&cycles_q))     cycles_q <= cycles_q + 1'b1;
  end

  always_comb begin
    cycles_rd = '0;
    cycles_rd[CTR_WIDTH-1:0] = cycles_q;
  end
`else
  assign cycles_rd = '0;
`endif

  always_comb begin
    prdata = '0;
    if (is_status)      prdata = {29'd0, state, core_busy};
    else if (is_irq)    prdata = {30'd0, enable, pending};
    else if (is_cycles) prdata = cycles_rd;
    else if (is_base)   prdata[ADDR_WIDTH-1:0] = base_q[base_sel];
  end

  // Top RSEL address bits select a region; remaining bits are an offset into it
  assign araddr = base_q[araddr_raw[ADDR_WIDTH-1 -: RSEL]] + (araddr_raw & LOW_MASK);
  assign awaddr = base_q[awaddr_raw[ADDR_WIDTH-1 -: RSEL]] + (awaddr_raw & LOW_MASK);

  logic unused_bits;
  assign unused_bits = ^{paddr[31:8], pwdata, base_off};

endmodule

// File: tb/tb_vx_ctrl_apb_multi.sv
// Scoreboarded bench for vx_ctrl_apb_multi; the expected CYCLES value follows VX_CTRL_CYCLE_CNT_EN.
module tb_vx_ctrl_apb_multi;
  localparam int NR = 4;
  localparam int D  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic        core_busy, core_clk_en, core_reset, irq;
  logic [31:0] araddr_raw, awaddr_raw, araddr, awaddr;

  vx_ctrl_apb_multi #(.NUM_REGIONS(NR), .ADDR_WIDTH(32), .RESET_DELAY(D), .CTR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .core_busy(core_busy), .core_clk_en(core_clk_en), .core_reset(core_reset),
    .araddr_raw(araddr_raw), .awaddr_raw(awaddr_raw), .araddr(araddr), .awaddr(awaddr),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] base_m [NR];
  logic        pend_m, en_m;
  int          phase_m;
  logic [31:0] cycles_m;

  typedef struct {
    logic        is_rd;
    logic        err;
    logic [31:0] data;
    logic [7:0]  off;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) base_m[i] = '0;
    pend_m = 1'b0; en_m = 1'b0; phase_m = 0; cycles_m = '0;
  endtask

  function automatic logic is_base_off(input logic [7:0] off);
    return (off[1:0] == 2'b00) && (off >= 8'h10) && (int'(off) < 16 + 4 * NR);
  endfunction

  function automatic logic model_err(input logic [7:0] off, input logic wr);
    logic mapped;
    mapped = (off == 8'h00) || (off == 8'h04) || (off == 8'h08) || (off == 8'h0C) || is_base_off(off);
    if (!mapped) return 1'b1;
    if (wr && (off == 8'h04 || off == 8'h0C)) return 1'b1;
    if (wr && is_base_off(off) && phase_m != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_rd(input logic [7:0] off);
    logic [1:0] ph;
    ph = phase_m[1:0];
    if (off == 8'h04) return {29'd0, ph, core_busy};
    if (off == 8'h08) return {30'd0, en_m, pend_m};
    if (off == 8'h0C) return cycles_m;
    if (is_base_off(off)) return base_m[(int'(off) - 16) / 4];
    return 32'd0;
  endfunction

  task automatic apply_write(input logic [7:0] off, input logic [31:0] data);
    if (off == 8'h00) begin
      if (data[1]) phase_m = 0;
      else if (data[0] && phase_m == 0) begin phase_m = 1; cycles_m = '0; end
    end else if (off == 8'h08) begin
      if (data[0]) pend_m = 1'b0;
      en_m = data[1];
    end else if (is_base_off(off)) begin
      base_m[(int'(off) - 16) / 4] = data;
    end
  endtask

  // Call at posedge+1; returns at commit edge+1
  task automatic apb(input logic wr, input logic [7:0] off, input logic [31:0] data);
    exp_t e;
    e.is_rd = ~wr; e.err = model_err(off, wr); e.data = model_rd(off); e.off = off;
    sb.push_back(e);
    psel = 1'b1; pwrite = wr; paddr = {24'($urandom()), off}; pwdata = data; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    if (wr && !e.err) apply_write(off, data);
  endtask

  always @(negedge clk) begin
    if (psel && penable) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL apb_unexpected: got access at 0x%02h expected none", paddr[7:0]);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("pslverr_%02h", e.off), {31'd0, pslverr}, {31'd0, e.err});
        if (e.is_rd) check($sformatf("prdata_%02h", e.off), prdata, e.data);
      end
    end
  end

  task automatic addr_checks(input int n);
    logic [31:0] ra, wa, er, ew;
    for (int i = 0; i < n; i++) begin
      ra = $urandom(); wa = $urandom();
      araddr_raw = ra; awaddr_raw = wa;
      er = base_m[ra[31:30]] + (ra & 32'h3FFF_FFFF);
      ew = base_m[wa[31:30]] + (wa & 32'h3FFF_FFFF);
      #1;
      check("araddr_rand", araddr, er);
      check("awaddr_rand", awaddr, ew);
    end
  endtask

  task automatic do_run(input int hold, input bit mid);
    int e_start, e_fall;
    apb(1'b1, 8'h00, 32'h1);
    e_start = edge_cnt;
    check("start_outs", {30'd0, core_clk_en, core_reset}, 32'd3);
    for (int k = 1; k < D; k++) begin
      @(posedge clk); #1;
      check("rst_hold", {30'd0, core_clk_en, core_reset}, 32'd3);
    end
    @(posedge clk); #1;
    phase_m = 2;
    check("run_entry", {30'd0, core_clk_en, core_reset}, 32'd2);
    apb(1'b0, 8'h04, 32'd0);
    core_busy = 1'b1;
    if (mid) begin
      apb(1'b1, 8'h10, $urandom());
      apb(1'b1, 8'h40, $urandom());
      apb(1'b1, 8'h04, $urandom());
      apb(1'b0, 8'h04, 32'd0);
    end
    repeat (hold) @(posedge clk);
    #1 core_busy = 1'b0;
    e_fall = edge_cnt + 1;
    @(posedge clk); #1;
    check("done_outs", {30'd0, core_clk_en, core_reset}, 32'd0);
    check("irq_before", {31'd0, irq}, {31'd0, pend_m & en_m});
    @(posedge clk); #1;
    pend_m = 1'b1; phase_m = 0;
`ifdef VX_CTRL_CYCLE_CNT_EN
    cycles_m = 32'(e_fall - e_start - D);
`else
    cycles_m = 32'd0;
`endif
    check("idle_outs", {30'd0, core_clk_en, core_reset}, 32'd1);
    check("irq_after", {31'd0, irq}, {31'd0, en_m});
  endtask

  initial begin
    reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; core_busy = 1'b0; araddr_raw = '0; awaddr_raw = '0;
    model_reset();
    #12;
    check("rst_outs", {28'd0, core_clk_en, core_reset, irq, pslverr}, 32'h4);
    @(posedge clk); #1 reset = 1'b1;

    for (int o = 0; o < 8'h24; o += 4) apb(1'b0, 8'(o), 32'd0);
    for (int i = 0; i < 10; i++) apb(1'b0, 8'($urandom()), 32'd0);

    apb(1'b1, 8'h10, $urandom());
    apb(1'b1, 8'h14, 32'h8000_0000);
    apb(1'b1, 8'h18, $urandom());
    apb(1'b1, 8'h1C, 32'hFFFF_FF00);
    for (int o = 8'h10; o < 8'h20; o += 4) apb(1'b0, 8'(o), 32'd0);
    araddr_raw = 32'h4000_0100; awaddr_raw = 32'hC000_0200; #1;
    check("araddr_r1", araddr, 32'h8000_0100);
    check("awaddr_r3_wrap", awaddr, 32'h0000_0100);
    addr_checks(12);

    apb(1'b1, 8'h08, 32'h2);
    do_run(100, 1'b0);
    apb(1'b0, 8'h0C, 32'd0);
    apb(1'b0, 8'h08, 32'd0);
    apb(1'b1, 8'h08, 32'h1);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    apb(1'b0, 8'h08, 32'd0);

    apb(1'b1, 8'h08, 32'h2);
    do_run($urandom_range(5, 40), 1'b1);
    apb(1'b0, 8'h10, 32'd0);
    apb(1'b0, 8'h0C, 32'd0);
    addr_checks(4);

    apb(1'b1, 8'h00, 32'h3);
    check("start_abort_outs", {30'd0, core_clk_en, core_reset}, 32'd1);
    apb(1'b0, 8'h04, 32'd0);
    apb(1'b1, 8'h00, 32'h1);
    @(posedge clk); #1;
    apb(1'b1, 8'h00, 32'h2);
    check("abort_outs", {30'd0, core_clk_en, core_reset}, 32'd1);
    apb(1'b0, 8'h04, 32'd0);
    apb(1'b0, 8'h08, 32'd0);

    apb(1'b1, 8'h00, 32'h1);
    repeat (D) @(posedge clk);
    #1 phase_m = 2; core_busy = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_outs", {29'd0, core_clk_en, core_reset, irq}, 32'h2);
    model_reset();
    core_busy = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    for (int o = 0; o < 8'h20; o += 4) apb(1'b0, 8'(o), 32'd0);
    addr_checks(4);

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
